// File: rtl/snake_body_streamer.sv
`default_nettype none
// ============================================================================
// Module      : snake_body_streamer
// Description : Snake segment store with move/grow handling, one-entry-per-
//               clock (body_count, x, y) stream and tail direction flags.
//               Optional macro SELF_COLLISION_EN adds the head/body sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_body_streamer #(
    parameter int SNAKE_LENGTH_BIT = 4,
    parameter int SNAKE_LENGTH_MAX = 16,
    parameter int INIT_LENGTH      = 2,
    parameter int INIT_HEAD_X      = 10,
    parameter int INIT_HEAD_Y      = 10,
    parameter int GRID_W           = 124,
    parameter int GRID_H           = 81
) (
    input  logic                        clock_25,
    input  logic                        reset,
    input  logic                        move_tick,
    input  logic                        grow,
    input  logic [6:0]                  head_x,
    input  logic [6:0]                  head_y,
    output logic [SNAKE_LENGTH_BIT-1:0] body_count,
    output logic [6:0]                  snake_body_x,
    output logic [6:0]                  snake_body_y,
    output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
    output logic                        up_tail,
    output logic                        down_tail,
    output logic                        left_tail,
    output logic                        right_tail,
    output logic                        self_hit
);

    localparam int                        c_depth    = SNAKE_LENGTH_MAX - 1;
    localparam logic [SNAKE_LENGTH_BIT-1:0] c_cnt_last = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 2);
    localparam logic [SNAKE_LENGTH_BIT-1:0] c_len_max  = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 1);
    localparam logic [SNAKE_LENGTH_BIT-1:0] c_one      = SNAKE_LENGTH_BIT'(1);
    localparam logic [SNAKE_LENGTH_BIT-1:0] c_two      = SNAKE_LENGTH_BIT'(2);
    localparam logic [6:0]                c_x_last   = 7'(GRID_W - 1);
    localparam logic [6:0]                c_y_last   = 7'(GRID_H - 1);

    logic [6:0]                  r_seg_x [0:c_depth-1];
    logic [6:0]                  r_seg_y [0:c_depth-1];
    logic [6:0]                  w_nxt_x [0:c_depth-1];
    logic [6:0]                  w_nxt_y [0:c_depth-1];
    logic [SNAKE_LENGTH_BIT-1:0] r_len;
    logic                        r_grow_pending;
    logic [SNAKE_LENGTH_BIT-1:0] r_cnt;
    logic [SNAKE_LENGTH_BIT-1:0] w_cnt_nxt;
    logic [6:0]                  r_x;
    logic [6:0]                  r_y;
    logic                        r_up, r_down, r_left, r_right;

    // Post-move view of the store; the stream reads from it so rows emitted
    // on the move edge already carry the shifted data.
    always_comb begin
        for (int k = 0; k < c_depth; k++) begin
            w_nxt_x[k] = r_seg_x[k];
            w_nxt_y[k] = r_seg_y[k];
        end
        if (move_tick) begin
            w_nxt_x[0] = head_x;
            w_nxt_y[0] = head_y;
            for (int k = 1; k < c_depth; k++) begin
                w_nxt_x[k] = r_seg_x[k-1];
                w_nxt_y[k] = r_seg_y[k-1];
            end
        end
    end

    assign w_cnt_nxt = (r_cnt == c_cnt_last) ? '0 : r_cnt + c_one;

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < c_depth; k++) begin
                r_seg_x[k] <= (k < INIT_LENGTH) ? 7'(INIT_HEAD_X - 1 - k) : 7'h7F;
                r_seg_y[k] <= (k < INIT_LENGTH) ? 7'(INIT_HEAD_Y) : 7'h7F;
            end
            r_len          <= SNAKE_LENGTH_BIT'(INIT_LENGTH);
            r_grow_pending <= 1'b0;
            r_cnt          <= '0;
            r_x            <= 7'(INIT_HEAD_X - 1);
            r_y            <= 7'(INIT_HEAD_Y);
        end else begin
            for (int k = 0; k < c_depth; k++) begin
                r_seg_x[k] <= w_nxt_x[k];
                r_seg_y[k] <= w_nxt_y[k];
            end
            if (move_tick) begin
                if ((r_grow_pending || grow) && (r_len != c_len_max))
                    r_len <= r_len + c_one;
                r_grow_pending <= 1'b0;
            end else if (grow) begin
                r_grow_pending <= 1'b1;
            end
            r_cnt <= w_cnt_nxt;
            r_x   <= w_nxt_x[w_cnt_nxt];
            r_y   <= w_nxt_y[w_cnt_nxt];
        end
    end

    logic [SNAKE_LENGTH_BIT-1:0] w_t_idx, w_p_idx;
    logic [6:0] w_tx, w_ty, w_px, w_py;
    logic [6:0] w_tx_inc, w_tx_dec, w_ty_inc, w_ty_dec;

    assign w_t_idx  = r_len - c_one;
    assign w_p_idx  = r_len - c_two;
    assign w_tx     = r_seg_x[w_t_idx];
    assign w_ty     = r_seg_y[w_t_idx];
    assign w_px     = r_seg_x[w_p_idx];
    assign w_py     = r_seg_y[w_p_idx];
    assign w_tx_inc = (w_tx == c_x_last) ? 7'd0 : w_tx + 7'd1;
    assign w_tx_dec = (w_tx == 7'd0) ? c_x_last : w_tx - 7'd1;
    assign w_ty_inc = (w_ty == c_y_last) ? 7'd0 : w_ty + 7'd1;
    assign w_ty_dec = (w_ty == 7'd0) ? c_y_last : w_ty - 7'd1;

    // Non-adjacent tail pair falls through every branch and holds the flags.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            {r_up, r_down, r_left, r_right} <= 4'b0001;
        end else if (w_py == w_ty && w_px == w_tx_inc) begin
            {r_up, r_down, r_left, r_right} <= 4'b0001;
        end else if (w_py == w_ty && w_px == w_tx_dec) begin
            {r_up, r_down, r_left, r_right} <= 4'b0010;
        end else if (w_px == w_tx && w_py == w_ty_inc) begin
            {r_up, r_down, r_left, r_right} <= 4'b0100;
        end else if (w_px == w_tx && w_py == w_ty_dec) begin
            {r_up, r_down, r_left, r_right} <= 4'b1000;
        end
    end

`ifdef SELF_COLLISION_EN
    logic r_sweep_hit, r_armed, r_self_hit, w_match;

    assign w_match = (r_cnt < r_len) && (r_x == head_x) && (r_y == head_y);

    // A sweep interrupted by a move is discarded; reporting resumes after
    // the next complete pass.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_sweep_hit <= 1'b0;
            r_armed     <= 1'b0;
            r_self_hit  <= 1'b0;
        end else if (move_tick) begin
            r_sweep_hit <= 1'b0;
            r_armed     <= 1'b0;
            r_self_hit  <= 1'b0;
        end else if (r_cnt == c_cnt_last) begin
            r_self_hit  <= r_armed && (r_sweep_hit || w_match);
            r_sweep_hit <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            r_self_hit  <= 1'b0;
            r_sweep_hit <= r_sweep_hit || w_match;
        end
    end

    assign self_hit = r_self_hit;
`else
    assign self_hit = 1'b0;
`endif

    assign body_count   = r_cnt;
    assign snake_body_x = r_x;
    assign snake_body_y = r_y;
    assign snake_length = r_len;
    assign up_tail      = r_up;
    assign down_tail    = r_down;
    assign left_tail    = r_left;
    assign right_tail   = r_right;

endmodule
`default_nettype wire

// File: tb/tb_snake_body_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_body_streamer
// Description : Scoreboard bench for snake_body_streamer (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_body_streamer;

    logic       clock_25 = 1'b0;
    logic       reset    = 1'b0;
    logic       move_tick = 1'b0;
    logic       grow     = 1'b0;
    logic [6:0] head_x   = 7'd0;
    logic [6:0] head_y   = 7'd0;
    logic [3:0] body_count, snake_length;
    logic [6:0] snake_body_x, snake_body_y;
    logic       up_tail, down_tail, left_tail, right_tail, self_hit;

    snake_body_streamer dut (
        .clock_25     (clock_25),
        .reset        (reset),
        .move_tick    (move_tick),
        .grow         (grow),
        .head_x       (head_x),
        .head_y       (head_y),
        .body_count   (body_count),
        .snake_body_x (snake_body_x),
        .snake_body_y (snake_body_y),
        .snake_length (snake_length),
        .up_tail      (up_tail),
        .down_tail    (down_tail),
        .left_tail    (left_tail),
        .right_tail   (right_tail),
        .self_hit     (self_hit)
    );

    always #20 clock_25 = ~clock_25;

    typedef struct {
        int         cnt;
        logic [6:0] x;
        logic [6:0] y;
        int         len;
        bit         chk_tail;
        logic [3:0] tail;   // {up, down, left, right}
        bit         hit;
    } item_t;

    item_t      q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         ph      = 0;
    logic [6:0] ex [15];
    logic [6:0] ey [15];
    int         elen;
    logic [3:0] etail;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: every streamed row with a pending expectation is compared.
    always @(negedge clock_25) begin
        if (q.size() > 0) begin
            item_t it;
            it = q.pop_front();
            chk("body_count",   int'(body_count),   it.cnt);
            chk("snake_body_x", int'(snake_body_x), int'(it.x));
            chk("snake_body_y", int'(snake_body_y), int'(it.y));
            chk("snake_length", int'(snake_length), it.len);
            chk("self_hit",     int'(self_hit),     int'(it.hit));
            if (it.chk_tail)
                chk("tail_flags", int'({up_tail, down_tail, left_tail, right_tail}), int'(it.tail));
        end
    end

    function automatic item_t mk(input int c, input bit ct, input bit h);
        item_t it;
        it.cnt = c; it.x = ex[c]; it.y = ey[c]; it.len = elen;
        it.chk_tail = ct; it.tail = etail; it.hit = h;
        return it;
    endfunction

    task automatic step(input bit do_push, input bit ct, input bit h);
        @(posedge clock_25);
        #1;
        ph = (ph == 14) ? 0 : ph + 1;
        if (do_push) q.push_back(mk(ph, ct, h));
    endtask

    task automatic exp_move(input logic [6:0] x, input logic [6:0] y, input bit g);
        for (int k = 14; k > 0; k--) begin
            ex[k] = ex[k-1];
            ey[k] = ey[k-1];
        end
        ex[0] = x; ey[0] = y;
        if (g && elen < 15) elen++;
    endtask

    task automatic do_move(input logic [6:0] x, input logic [6:0] y, input bit g,
                           input bit pend, input bit ct);
        move_tick = 1'b1; grow = g; head_x = x; head_y = y;
        exp_move(x, y, g | pend);
        step(1'b1, ct, 1'b0);
        move_tick = 1'b0; grow = 1'b0; head_x = 7'd0; head_y = 7'd0;
    endtask

    task automatic reset_expect();
        for (int k = 0; k < 15; k++) begin ex[k] = 7'h7F; ey[k] = 7'h7F; end
        ex[0] = 7'd9; ey[0] = 7'd10; ex[1] = 7'd8; ey[1] = 7'd10;
        elen = 2; etail = 4'b0001;
    endtask

    initial begin
        reset_expect();
        // reset state
        q.push_back(mk(0, 1'b1, 1'b0));
        @(posedge clock_25); #1;
        reset = 1'b1; ph = 0;

        // initial sweep and wrap
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0);

        // plain move, length unchanged
        do_move(7'd10, 7'd10, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0);

        // grow, then move five clocks later
        grow = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        grow = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        do_move(7'd11, 7'd10, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0);

        // grow to the maximum, then move+grow at saturation
        for (int i = 0; i < 12; i++) do_move(7'(12 + i), 7'd10, 1'b1, 1'b0, 1'b1);
        do_move(7'd24, 7'd10, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0);

        // tail (0,5) with predecessor (123,5): wrapped left
        for (int i = 0; i < 15; i++)
            do_move((i == 0) ? 7'd0 : 7'(124 - i), 7'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        etail = 4'b0010;
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0);

        // head parked on segment 1 (111,5) starting at phase 14
        while (ph != 14) step(1'b1, 1'b1, 1'b0);
        head_x = 7'd111; head_y = 7'd5;
        for (int i = 1; i <= 30; i++) begin
`ifdef SELF_COLLISION_EN
            step(1'b1, 1'b1, (i % 15 == 0));
`else
            step(1'b1, 1'b1, 1'b0);
`endif
        end
        head_x = 7'd0; head_y = 7'd0;

        // asynchronous reset in the middle of a sweep
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        #4;
        reset = 1'b0;
        reset_expect();
        q.push_back(mk(0, 1'b1, 1'b0));
        @(posedge clock_25); #1;
        reset = 1'b1; ph = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);

        // drain the scoreboard, bounded
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clock_25);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d items left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
